multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control unit for the ARM-subset processor.
- Sequences the shared datapath (PC, instruction/data memory, register file, ALU, extender, muxes) through fetch/decode/execute/memory/writeback states.
- Takes the decoded instruction fields and ALU flags. Drives every write enable and mux select.
- Holds the NZCV flag register and evaluates the condition field, so predicated instructions commit nothing when the condition fails.

Parameters:
- FLAGS_RST, 4'b0000, reset value of the NZCV register.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  level; 1 starts/keeps execution, sampled in IDLE and at end of instruction
- cond  input  4  instruction [31:28], stable from DECODE onward (IR latched)
- op  input  2  instruction [27:26]; 00 data-proc, 01 memory, 10 branch, 11 illegal
- imm_i  input  1  I bit (data-proc immediate operand)
- opcode  input  4  data-proc opcode [24:21]
- s_bit  input  1  S bit (data-proc flag update)
- l_bit  input  1  load/store bit; 1 = LDR
- rd  input  4  destination register
- alu_flags  input  4  NZCV from ALU, same cycle
- pc_we  output  1  PC write enable
- ir_we  output  1  instruction register write enable
- adr_src  output  1  memory address select; 0 = PC, 1 = ALU-out register
- mem_we  output  1  data memory write enable
- reg_we  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = RD1
- alu_src_b  output  2  00 = RD2, 01 = extended immediate, 10 = constant 4
- alu_ctrl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- result_src  output  2  00 ALU-out register, 01 memory read data, 10 ALU result direct
- imm_src  output  2  00 imm8, 01 imm12, 10 imm24 shifted left 2
- flags  output  4  current NZCV register
- busy  output  1  1 in every state except IDLE
- illegal  output  1  one-cycle pulse on unsupported op/opcode

Behaviour:
- Reset: state IDLE, flags = FLAGS_RST, all enables 0, all selects 0.
- Outputs are Moore decodes of state. Write enables are additionally ANDed with cond_ex in execute/writeback states.
- cond_ex: combinational from cond and flags. Codes:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N
  - GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&&N==V; LE 1101 Z||N!=V; AL 1110 1
  - All other codes: 0.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: ir_we=1, adr_src=0, alu_src_a=0, alu_src_b=10, ADD, result_src=10, pc_we=1 (PC += 4) -> DECODE.
  - DECODE: ALU computes PC+8 for R15 reads.
    - op 00 -> EXEC_DP. op 01 -> MEMADR. op 10 -> BRANCH.
    - op 11 or unsupported opcode -> FETCH with illegal=1.
  - EXEC_DP: alu_src_a=1; alu_src_b = imm_i ? 01 : 00; imm_src=00.
    - Opcode map: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB). All others illegal.
    - -> ALUWB.
  - ALUWB: result_src=00.
    - reg_we = cond_ex && opcode!=CMP && rd!=15.
    - rd==15 with cond_ex: pc_we=1, reg_we=0.
    - Flags <= alu_flags captured in EXEC_DP when (s_bit || CMP) && cond_ex.
    - -> FETCH, or IDLE if start=0.
  - MEMADR: ADD, alu_src_a=1, alu_src_b=01, imm_src=01. l_bit -> MEMRD, else -> MEMWR.
  - MEMWR: adr_src=1, mem_we=cond_ex -> FETCH/IDLE.
  - MEMRD: adr_src=1 -> MEMWB.
  - MEMWB: result_src=01, reg_we=cond_ex (pc_we instead if rd==15) -> FETCH/IDLE.
  - BRANCH: alu_src_a=0, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_we=cond_ex -> FETCH/IDLE.
- Latency in cycles: data-proc 4, STR 4, LDR 5, B 3. IDLE->FETCH takes 1 cycle.
- Flags are captured at the end of EXEC_DP from alu_flags into a pending register and committed in ALUWB. They never change in any other state.
- start deasserted mid-instruction: the instruction completes, then IDLE.
- rst mid-instruction: immediate IDLE. No partial write is allowed after rst rises.

Decomposition:
- Package ctrl_pkg: state enum, alu_ctrl/alu_src_b/result_src/imm_src encodings, opcode constants, cond code constants.
- Sub-module cond_check: pure combinational cond + flags -> cond_ex.

Test Plan:
- rst=1 mid-MEMRD -> state IDLE, flags=0000, all enables 0 the same cycle, regardless of clk.
- start=1; ADD AL, s_bit=1, alu_flags=0100 -> reg_we in cycle 4 only; flags=0100 after ALUWB; pc_we only in FETCH.
- CMP AL giving alu_flags=0100, then BNE (cond 0001) -> BRANCH state with pc_we=0; next BEQ (0000) -> pc_we=1 in BRANCH.
- LDR AL with rd=3 -> adr_src=1 in MEMRD and MEMWB; reg_we=1 with result_src=01 only in cycle 5. STR -> mem_we=1 only in MEMWR.
- ADD with cond=1110, rd=15 -> reg_we=0, pc_we=1 in ALUWB. op=11 -> illegal pulse 1 cycle, no writes, back to FETCH.
- start dropped during EXEC_DP -> ALUWB completes, then IDLE, busy=0. start=1 again -> FETCH next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and encodings for the multicycle ARM-subset control unit:
//   - state_t          : controller FSM states
//   - ALU_*            : alu_ctrl encodings
//   - SRCB_*           : alu_src_b encodings
//   - RES_*            : result_src encodings
//   - IMM_*            : imm_src encodings
//   - OP_* / DP_*      : instruction class and data-processing opcodes
//   - CC_*             : condition field codes
// Helpers: dp_legal() and dp_alu_ctrl() map a data-processing opcode.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_DP = 4'd3,
    S_ALUWB   = 4'd4,
    S_MEMADR  = 4'd5,
    S_MEMWR   = 4'd6,
    S_MEMRD   = 4'd7,
    S_MEMWB   = 4'd8,
    S_BRANCH  = 4'd9
  } state_t;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALU B operand
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Register-file write data / PC source
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Immediate extender format
  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  // Instruction class (instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Supported data-processing opcodes
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_ORR = 4'b1100;

  // Register number of the PC
  localparam logic [3:0] REG_PC = 4'd15;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  function automatic logic dp_legal(input logic [3:0] opc);
    return (opc == DP_AND) || (opc == DP_SUB) || (opc == DP_ADD) ||
           (opc == DP_CMP) || (opc == DP_ORR);
  endfunction

  // CMP is a subtract whose result is discarded.
  function automatic logic [1:0] dp_alu_ctrl(input logic [3:0] opc);
    logic [1:0] ctl;
    case (opc)
      DP_ADD:  ctl = ALU_ADD;
      DP_SUB:  ctl = ALU_SUB;
      DP_CMP:  ctl = ALU_SUB;
      DP_AND:  ctl = ALU_AND;
      DP_ORR:  ctl = ALU_ORR;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ---------------------------------------------------------------------------
// cond_check
// Pure combinational condition evaluation for predicated instructions.
// Ports:
//   i_cond    [3:0]  condition field of the instruction
//   i_flags   [3:0]  current NZCV flags (N=3, Z=2, C=1, V=0)
//   o_cond_ex        1 when the instruction must execute
// Codes outside the supported set never execute.
// ---------------------------------------------------------------------------
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;
  logic w_ge;

  assign w_n  = i_flags[3];
  assign w_z  = i_flags[2];
  assign w_c  = i_flags[1];
  assign w_v  = i_flags[0];
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      CC_EQ:   o_cond_ex = w_z;
      CC_NE:   o_cond_ex = !w_z;
      CC_CS:   o_cond_ex = w_c;
      CC_CC:   o_cond_ex = !w_c;
      CC_MI:   o_cond_ex = w_n;
      CC_PL:   o_cond_ex = !w_n;
      CC_GE:   o_cond_ex = w_ge;
      CC_LT:   o_cond_ex = !w_ge;
      CC_GT:   o_cond_ex = !w_z && w_ge;
      CC_LE:   o_cond_ex = w_z || !w_ge;
      CC_AL:   o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for the multicycle ARM-subset processor. Sequences the shared
// datapath through fetch/decode/execute/memory/writeback, owns the NZCV
// register and suppresses all commits of instructions whose condition fails.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               run request, sampled in IDLE and at end of instruction
//   cond, op, imm_i,
//   opcode, s_bit,
//   l_bit, rd           decoded instruction fields (stable from DECODE on)
//   alu_flags           NZCV produced by the ALU this cycle
//   pc_we, ir_we,
//   mem_we, reg_we      write enables
//   adr_src, alu_src_a,
//   alu_src_b, alu_ctrl,
//   result_src, imm_src datapath selects
//   flags               current NZCV register
//   busy                high outside IDLE
//   illegal             one-cycle pulse in DECODE for unsupported encodings
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic       imm_i,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  input  logic       l_bit,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_we,
  output logic       ir_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [3:0] flags,
  output logic       busy,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_state_next;
  state_t     w_end_next;
  logic [3:0] r_flags;
  logic [3:0] r_flags_pend;
  logic       w_cond_ex;
  logic       w_is_cmp;
  logic       w_rd_pc;
  logic       w_illegal_dec;
  logic       w_flag_upd;

  cond_check u_cond_check (
    .i_cond    (cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_is_cmp      = (opcode == DP_CMP);
  assign w_rd_pc       = (rd == REG_PC);
  assign w_illegal_dec = (op == 2'b11) || ((op == OP_DP) && !dp_legal(opcode));
  // cond_ex is evaluated against the flags held before this instruction,
  // since the commit happens on the same edge that leaves ALUWB.
  assign w_flag_upd    = (s_bit || w_is_cmp) && w_cond_ex;
  assign w_end_next    = start ? S_FETCH : S_IDLE;
  assign flags         = r_flags;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flags: ALU result flags are latched at the end of EXEC_DP so the ALU is
  // free during ALUWB, then committed only from ALUWB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags      <= FLAGS_RST;
      r_flags_pend <= 4'b0000;
    end else begin
      if (r_state == S_EXEC_DP) begin
        r_flags_pend <= alu_flags;
      end
      if ((r_state == S_ALUWB) && w_flag_upd) begin
        r_flags <= r_flags_pend;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    w_state_next = start ? S_FETCH : S_IDLE;
      S_FETCH:   w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_illegal_dec) begin
          w_state_next = S_FETCH;
        end else begin
          case (op)
            OP_DP:   w_state_next = S_EXEC_DP;
            OP_MEM:  w_state_next = S_MEMADR;
            OP_BR:   w_state_next = S_BRANCH;
            default: w_state_next = S_FETCH;
          endcase
        end
      end
      S_EXEC_DP: w_state_next = S_ALUWB;
      S_ALUWB:   w_state_next = w_end_next;
      S_MEMADR:  w_state_next = l_bit ? S_MEMRD : S_MEMWR;
      S_MEMWR:   w_state_next = w_end_next;
      S_MEMRD:   w_state_next = S_MEMWB;
      S_MEMWB:   w_state_next = w_end_next;
      S_BRANCH:  w_state_next = w_end_next;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    adr_src    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALUOUT;
    imm_src    = IMM_8;
    busy       = (r_state != S_IDLE);
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        // PC already advanced by 4, so PC+4 here gives the R15 read value PC+8.
        alu_src_b  = SRCB_FOUR;
        illegal    = w_illegal_dec;
      end
      S_EXEC_DP: begin
        alu_src_a  = 1'b1;
        alu_src_b  = imm_i ? SRCB_IMM : SRCB_RD2;
        imm_src    = IMM_8;
        alu_ctrl   = dp_alu_ctrl(opcode);
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_we     = w_cond_ex && !w_is_cmp && !w_rd_pc;
        pc_we      = w_cond_ex && !w_is_cmp && w_rd_pc;
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_12;
      end
      S_MEMWR: begin
        adr_src    = 1'b1;
        mem_we     = w_cond_ex;
      end
      S_MEMRD: begin
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        adr_src    = 1'b1;
        result_src = RES_MEM;
        reg_we     = w_cond_ex && !w_rd_pc;
        pc_we      = w_cond_ex && w_rd_pc;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_24;
        result_src = RES_ALU;
        pc_we      = w_cond_ex;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Drives whole instructions into multicycle_ctrl and compares every cycle's
// outputs against a per-instruction-class, per-cycle reference table.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_i;
  logic [3:0] opcode;
  logic       s_bit;
  logic       l_bit;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_we, ir_we, adr_src, mem_we, reg_we, alu_src_a;
  logic [1:0] alu_src_b, alu_ctrl, result_src, imm_src;
  logic [3:0] flags;
  logic       busy, illegal;

  multicycle_ctrl #(.FLAGS_RST(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cond       (cond),
    .op         (op),
    .imm_i      (imm_i),
    .opcode     (opcode),
    .s_bit      (s_bit),
    .l_bit      (l_bit),
    .rd         (rd),
    .alu_flags  (alu_flags),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .adr_src    (adr_src),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .result_src (result_src),
    .imm_src    (imm_src),
    .flags      (flags),
    .busy       (busy),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       adr_src;
    logic       mem_we;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       busy;
    logic       illegal;
    logic [3:0] flags;
  } ovec_t;

  typedef enum int {K_DP, K_STR, K_LDR, K_B, K_ILL} kind_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] m_flags;      // reference NZCV register

  task automatic check(input string tag, input ovec_t got, input ovec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic ovec_t observe();
    ovec_t v;
    v = '{pc_we, ir_we, adr_src, mem_we, reg_we, alu_src_a, alu_src_b,
          alu_ctrl, result_src, imm_src, busy, illegal, flags};
    return v;
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU operation of a data-proc opcode; 4'hF marks an unsupported opcode.
  function automatic logic [3:0] dp_op(input logic [3:0] opc);
    case (opc)
      4'b0100: return 4'd0;
      4'b0010: return 4'd1;
      4'b1010: return 4'd1;
      4'b0000: return 4'd2;
      4'b1100: return 4'd3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic kind_t classify(input logic [1:0] o, input logic [3:0] opc,
                                     input logic l);
    if (o == 2'b00) return (dp_op(opc) == 4'hF) ? K_ILL : K_DP;
    if (o == 2'b01) return l ? K_LDR : K_STR;
    if (o == 2'b10) return K_B;
    return K_ILL;
  endfunction

  function automatic int instr_len(input kind_t k);
    case (k)
      K_DP:    return 4;
      K_STR:   return 4;
      K_LDR:   return 5;
      K_B:     return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = fetch) of an instruction of class kind.
  function automatic ovec_t expect_out(input kind_t kind, input int k,
                                       input logic imm, input logic [3:0] opc,
                                       input logic [3:0] r, input logic [3:0] f,
                                       input logic ce);
    ovec_t e;
    logic  writes, to_pc;
    e       = '0;
    e.flags = f;
    e.busy  = 1'b1;
    to_pc   = (r == 4'd15);
    if (k == 0) begin
      e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    end else if (k == 1) begin
      e.alu_src_b = 2'b10;
      e.illegal   = (kind == K_ILL);
    end else begin
      case (kind)
        K_DP: begin
          if (k == 2) begin
            e.alu_src_a = 1'b1;
            e.alu_src_b = imm ? 2'b01 : 2'b00;
            e.alu_ctrl  = dp_op(opc)[1:0];
          end else begin
            writes   = ce && (opc != 4'b1010);
            e.reg_we = writes && !to_pc;
            e.pc_we  = writes && to_pc;
          end
        end
        K_STR, K_LDR: begin
          if (k == 2) begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b01; e.imm_src = 2'b01;
          end else if (k == 3) begin
            e.adr_src = 1'b1;
            e.mem_we  = (kind == K_STR) && ce;
          end else begin
            e.adr_src    = 1'b1;
            e.result_src = 2'b01;
            e.reg_we     = ce && !to_pc;
            e.pc_we      = ce && to_pc;
          end
        end
        K_B: begin
          e.alu_src_b = 2'b01; e.imm_src = 2'b10; e.result_src = 2'b10;
          e.pc_we     = ce;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic ovec_t idle_vec(input logic [3:0] f);
    ovec_t e;
    e       = '0;
    e.flags = f;
    return e;
  endfunction

  // Runs one instruction starting with the edge that enters FETCH.
  // se is the start level at the end of the instruction; abort_k >= 0 raises
  // rst between clock edges in that cycle.
  task automatic run_instr(input string name, input logic [3:0] c,
                           input logic [1:0] o, input logic imm,
                           input logic [3:0] opc, input logic s, input logic l,
                           input logic [3:0] r, input logic [3:0] af,
                           input logic se, input int abort_k);
    kind_t      kind;
    int         len;
    logic       ce;
    logic [3:0] f0;
    kind = classify(o, opc, l);
    len  = instr_len(kind);
    f0   = m_flags;
    ce   = cond_ok(c, f0);
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        cond = c; op = o; imm_i = imm; opcode = opc; s_bit = s; l_bit = l;
        rd = r; alu_flags = af;
      end
      if (k == 1) start = 1'($urandom_range(0, 1));
      // Flags must come from the EXEC_DP capture, not the ALU during ALUWB.
      if (k == 3 && kind == K_DP) alu_flags = 4'($urandom);
      if (k == len - 1) start = se;
      check($sformatf("%s.cyc%0d", name, k), observe(),
            expect_out(kind, k, imm, opc, r, f0, ce));
      if (k == abort_k) begin
        #2 rst = 1'b1;
        #1;
        m_flags = 4'b0000;
        check($sformatf("%s.rst", name), observe(), idle_vec(m_flags));
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        $display("instr %-8s aborted by reset in cycle %0d", name, k);
        return;
      end
    end
    if (kind == K_DP && (s || opc == 4'b1010) && ce) m_flags = af;
    $display("instr %-8s cond=%h op=%0d opc=%h rd=%0d ce=%0b flags=%h",
             name, c, o, opc, r, ce, m_flags);
    if (kind != K_ILL && !se) begin
      @(posedge clk);
      #1;
      check($sformatf("%s.idle", name), observe(), idle_vec(m_flags));
      start = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] legal [5];
    logic [3:0] c, opc, r;
    logic [1:0] o;
    int         sel;
    legal[0] = 4'b0100; legal[1] = 4'b0010; legal[2] = 4'b0000;
    legal[3] = 4'b1100; legal[4] = 4'b1010;

    rst = 1'b1; start = 1'b0; cond = '0; op = '0; imm_i = 1'b0; opcode = '0;
    s_bit = 1'b0; l_bit = 1'b0; rd = '0; alu_flags = '0;
    m_flags = 4'b0000;
    #1;
    check("reset", observe(), idle_vec(m_flags));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_hold", observe(), idle_vec(m_flags));
    start = 1'b1;

    // Directed sequence
    run_instr("ADDS",  4'hE, 2'b00, 1'b0, 4'b0100, 1'b1, 1'b0, 4'd2,  4'b0100, 1'b1, -1);
    run_instr("CMP",   4'hE, 2'b00, 1'b1, 4'b1010, 1'b0, 1'b0, 4'd0,  4'b0100, 1'b1, -1);
    run_instr("BNE",   4'h1, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b1, -1);
    run_instr("BEQ",   4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0,  4'b0000, 1'b1, -1);
    run_instr("LDR",   4'hE, 2'b01, 1'b1, 4'b1100, 1'b0, 1'b1, 4'd3,  4'b0000, 1'b1, -1);
    run_instr("STR",   4'hE, 2'b01, 1'b1, 4'b1100, 1'b0, 1'b0, 4'd3,  4'b0000, 1'b1, -1);
    run_instr("ADDPC", 4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 1'b0, 4'd15, 4'b0000, 1'b1, -1);
    run_instr("ILLOP", 4'hE, 2'b11, 1'b0, 4'b0100, 1'b0, 1'b0, 4'd1,  4'b0000, 1'b0, -1);
    run_instr("ILLOPC",4'hE, 2'b00, 1'b0, 4'b0110, 1'b0, 1'b0, 4'd1,  4'b0000, 1'b1, -1);
    run_instr("ORRNV", 4'hF, 2'b00, 1'b0, 4'b1100, 1'b1, 1'b0, 4'd4,  4'b1111, 1'b1, -1);
    run_instr("SUBSTP",4'hE, 2'b00, 1'b0, 4'b0010, 1'b1, 1'b0, 4'd5,  4'b1001, 1'b0, -1);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      c   = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      r   = 4'($urandom);
      opc = legal[$urandom_range(0, 4)];
      if (sel <= 3)      o = 2'b00;
      else if (sel <= 5) o = 2'b01;
      else if (sel <= 7) o = 2'b10;
      else if (sel == 8) o = 2'b11;
      else begin
        o   = 2'b00;
        opc = 4'($urandom);
      end
      if (o == 2'b00 && opc == 4'b1010 && r == 4'd15) r = 4'd14;
      run_instr($sformatf("R%0d", i), c, o, 1'($urandom), opc, 1'($urandom),
                1'($urandom), r, 4'($urandom), ($urandom_range(0, 7) != 0), -1);
    end

    // Reset in the middle of a load, with nonzero flags beforehand
    run_instr("SETFLG", 4'hE, 2'b00, 1'b0, 4'b0100, 1'b1, 1'b0, 4'd1, 4'b1010, 1'b1, -1);
    run_instr("LDRRST", 4'hE, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b1, 4'd3, 4'b0000, 1'b1, 3);
    run_instr("POSTRST",4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
